// File: rtl/wb_interconnect_1xn.sv
// wb_interconnect_1xn: single-master N-slave Wishbone interconnect with registered decode, default error slave and strobe timeout
module wb_interconnect_1xn #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_SLAVES       = 4,
  parameter logic [N_SLAVES-1:0][WB_ADDR_WIDTH-1:0] ADDR_BASES  = '0,
  parameter logic [N_SLAVES-1:0][WB_ADDR_WIDTH-1:0] ADDR_LIMITS = '0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          m0_cyc,
  input  logic                                          m0_stb,
  input  logic                                          m0_we,
  input  logic [WB_ADDR_WIDTH-1:0]                      m0_adr,
  input  logic [WB_DATA_WIDTH-1:0]                      m0_dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0]                    m0_sel,
  input  logic [2:0]                                    m0_cti,
  input  logic [1:0]                                    m0_bte,
  output logic                                          m0_ack,
  output logic                                          m0_err,
  output logic [WB_DATA_WIDTH-1:0]                      m0_dat_r,
  output logic [N_SLAVES-1:0]                           s_cyc,
  output logic [N_SLAVES-1:0]                           s_stb,
  output logic [N_SLAVES-1:0]                           s_we,
  output logic [N_SLAVES-1:0][WB_ADDR_WIDTH-1:0]        s_adr,
  output logic [N_SLAVES-1:0][WB_DATA_WIDTH-1:0]        s_dat_w,
  output logic [N_SLAVES-1:0][WB_DATA_WIDTH/8-1:0]      s_sel,
  output logic [N_SLAVES-1:0][2:0]                      s_cti,
  output logic [N_SLAVES-1:0][1:0]                      s_bte,
  input  logic [N_SLAVES-1:0]                           s_ack,
  input  logic [N_SLAVES-1:0]                           s_err,
  input  logic [N_SLAVES-1:0][WB_DATA_WIDTH-1:0]        s_dat_r,
  output logic                                          decerr,
  output logic                                          timeout
);
  localparam int SW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, ROUTE, ERR, WAIT} state_t;
  state_t state, state_n;
  logic [SW-1:0] sel, hit_idx;
  logic [TW-1:0] tcnt;
  logic [N_SLAVES-1:0] en;
  logic hit, cause_to, stall, expire;
  // descending scan so the lowest matching index wins on overlap
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--)
      if (m0_adr >= ADDR_BASES[i] && m0_adr <= ADDR_LIMITS[i]) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
  end
  assign stall  = state == ROUTE && m0_stb && !s_ack[sel] && !s_err[sel];
  assign expire = TIMEOUT_CYCLES != 0 && stall && tcnt == TLAST;
  assign en     = state == ROUTE ? N_SLAVES'(1) << sel : '0;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      sel      <= '0;
      tcnt     <= '0;
      cause_to <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && m0_cyc && m0_stb && hit) sel <= hit_idx;
      tcnt <= stall ? tcnt + 1'b1 : '0;
      if (state_n == ERR) cause_to <= state == ROUTE;
    end
  always_comb
    unique case (state)
      IDLE:    state_n = m0_cyc && m0_stb ? (hit ? ROUTE : ERR) : IDLE;
      ROUTE:   state_n = !m0_cyc ? IDLE : expire ? ERR : ROUTE;
      ERR:     state_n = WAIT;
      default: state_n = m0_cyc ? WAIT : IDLE;
    endcase
  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) begin
      s_cyc[i]   = en[i] & m0_cyc;
      s_stb[i]   = en[i] & m0_stb;
      s_we[i]    = en[i] & m0_we;
      s_adr[i]   = en[i] ? m0_adr : '0;
      s_dat_w[i] = en[i] ? m0_dat_w : '0;
      s_sel[i]   = en[i] ? m0_sel : '0;
      s_cti[i]   = en[i] ? m0_cti : '0;
      s_bte[i]   = en[i] ? m0_bte : '0;
    end
    m0_ack   = state == ROUTE && s_ack[sel];
    m0_err   = state == ERR || (state == ROUTE && s_err[sel]);
    m0_dat_r = state == ROUTE ? s_dat_r[sel] : '0;
    decerr   = state == ERR && !cause_to;
    timeout  = state == ERR && cause_to;
  end
endmodule

// File: tb/tb_wb_interconnect_1xn.sv
// tb_wb_interconnect_1xn: directed vector table plus burst and reset sequences for wb_interconnect_1xn
module tb_wb_interconnect_1xn;
  localparam int N = 4;
  logic clk = 1'b0, rstn = 1'b0;
  logic m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_adr = '0, m0_dat_w = 32'h5A5A_0001;
  logic [3:0] m0_sel = 4'hF;
  logic [2:0] m0_cti = '0;
  logic [1:0] m0_bte = '0;
  logic m0_ack, m0_err, decerr, timeout;
  logic [31:0] m0_dat_r;
  logic [N-1:0] s_cyc, s_stb, s_we, s_ack, s_err;
  logic [N-1:0][31:0] s_adr, s_dat_w, s_dat_r;
  logic [N-1:0][3:0] s_sel;
  logic [N-1:0][2:0] s_cti;
  logic [N-1:0][1:0] s_bte;
  int wait_n = 0, stall_cnt = 0;
  logic serr = 1'b0;
  int n_tests = 0, n_fail = 0;

  wb_interconnect_1xn #(
    .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_SLAVES(N),
    .ADDR_BASES ({32'h3000, 32'h2000, 32'h0400, 32'h0000}),
    .ADDR_LIMITS({32'h3FFF, 32'h2FFF, 32'h1FFF, 32'h0FFF}),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_r(m0_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
    .decerr(decerr), .timeout(timeout)
  );

  always #5 clk = ~clk;
  // slave model: respond after wait_n stalled cycles with a fixed per-slave word
  assign s_dat_r = {32'h4444_0000, 32'hCAFE_F00D, 32'h2222_0000, 32'h1111_0000};
  assign s_ack = (!serr && stall_cnt == wait_n) ? s_stb : '0;
  assign s_err = (serr && stall_cnt == wait_n) ? s_stb : '0;
  always @(posedge clk) stall_cnt <= (|s_stb && !(|s_ack) && !(|s_err)) ? stall_cnt + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string name; logic [31:0] adr; logic we; int wait_n; logic serr;
    int rc; logic err; logic [31:0] dat; logic [3:0] mask; int stb_n; logic dec; logic to; logic cyc;
  } vec_t;
  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    int rc, post, stb_n, err_n, ack_n, dec_n, to_n;
    logic [3:0] mask;
    logic [31:0] dat;
    logic cyc;
    rc = -1; post = 0; stb_n = 0; err_n = 0; ack_n = 0; dec_n = 0; to_n = 0;
    mask = '0; dat = '0; cyc = 1'b0;
    wait_n = v.wait_n; serr = v.serr;
    @(negedge clk);
    m0_adr = v.adr; m0_we = v.we; m0_cti = '0; m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int c = 1; c <= 30 && post < 3; c++) begin
      @(negedge clk);
      mask |= s_stb;
      stb_n += int'(|s_stb);
      err_n += int'(m0_err);
      ack_n += int'(m0_ack);
      dec_n += int'(decerr);
      to_n  += int'(timeout);
      if (rc >= 0) post++;
      else if (m0_ack || m0_err) begin
        rc = c; dat = m0_dat_r; cyc = |s_cyc;
        m0_cyc = 1'b0; m0_stb = 1'b0;
      end
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    chk({v.name, " resp_cycle"}, 32'(rc), 32'(v.rc));
    chk({v.name, " err_cycles"}, 32'(err_n), 32'(v.err));
    chk({v.name, " ack_cycles"}, 32'(ack_n), 32'(!v.err));
    chk({v.name, " dat_r"}, dat, v.dat);
    chk({v.name, " stb_mask"}, 32'(mask), 32'(v.mask));
    chk({v.name, " stb_cycles"}, 32'(stb_n), 32'(v.stb_n));
    chk({v.name, " decerr"}, 32'(dec_n), 32'(v.dec));
    chk({v.name, " timeout"}, 32'(to_n), 32'(v.to));
    chk({v.name, " s_cyc_at_resp"}, 32'(cyc), 32'(v.cyc));
  endtask

  initial begin
    vecs[0] = '{"rd_s2",      32'h2004, 1'b0, 0,    1'b0, 1, 1'b0, 32'hCAFE_F00D, 4'b0100, 1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"wr_s0",      32'h0010, 1'b1, 0,    1'b0, 1, 1'b0, 32'h1111_0000, 4'b0001, 1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"rd_s3_wait", 32'h3FFC, 1'b0, 2,    1'b0, 3, 1'b0, 32'h4444_0000, 4'b1000, 3, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"miss_8000",  32'h8000, 1'b0, 0,    1'b0, 1, 1'b1, 32'h0,         4'b0000, 0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"timeout_s1", 32'h1800, 1'b0, 1000, 1'b0, 5, 1'b1, 32'h0,         4'b0010, 4, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"ack_at_thr", 32'h1000, 1'b0, 3,    1'b0, 4, 1'b0, 32'h2222_0000, 4'b0010, 4, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{"overlap_500",32'h0500, 1'b0, 0,    1'b0, 1, 1'b0, 32'h1111_0000, 4'b0001, 1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{"slave_err",  32'h2FFF, 1'b0, 1,    1'b1, 2, 1'b1, 32'hCAFE_F00D, 4'b0100, 2, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{"miss_4000",  32'h4000, 1'b0, 0,    1'b0, 1, 1'b1, 32'h0,         4'b0000, 0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{"edge_0fff",  32'h0FFF, 1'b0, 0,    1'b0, 1, 1'b0, 32'h1111_0000, 4'b0001, 1, 1'b0, 1'b0, 1'b1};
    repeat (2) @(negedge clk);
    chk("reset s_cyc", 32'(s_cyc), 32'h0);
    chk("reset m0_ack_err", 32'({m0_ack, m0_err}), 32'h0);
    chk("reset pulses", 32'({decerr, timeout}), 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    // incrementing burst crossing into the s1 range stays locked on s0
    wait_n = 0; serr = 1'b0;
    @(negedge clk);
    m0_adr = 32'h0FF8; m0_cti = 3'b010; m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("burst%0d stb", k), 32'(s_stb), 32'h1);
      chk($sformatf("burst%0d adr", k), s_adr[0], 32'h0FF8 + 32'(4 * (k - 1)));
      chk($sformatf("burst%0d ack", k), 32'(m0_ack), 32'h1);
      m0_adr = m0_adr + 32'd4;
      if (k == 3) m0_cti = 3'b111;
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_cti = '0;
    repeat (2) @(negedge clk);
    // asynchronous reset while s3 is stalled in ROUTE
    wait_n = 1000;
    m0_adr = 32'h3000; m0_cyc = 1'b1; m0_stb = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre-reset s_stb", 32'(s_stb), 32'h8);
    rstn = 1'b0;
    #1;
    chk("async reset s_cyc_stb", 32'({s_cyc, s_stb}), 32'h0);
    chk("async reset s_adr3", s_adr[3], 32'h0);
    chk("async reset m0", 32'({m0_ack, m0_err}), 32'h0);
    chk("async reset m0_dat_r", m0_dat_r, 32'h0);
    chk("async reset pulses", 32'({decerr, timeout}), 32'h0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_vec('{"post_reset_s1", 32'h1000, 1'b0, 0, 1'b0, 1, 1'b0, 32'h2222_0000, 4'b0010, 1, 1'b0, 1'b0, 1'b1});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
